card_match_engine: RTL and testbench
====================================

Name: card_match_engine

Overview:
- Parametrised pair-matching engine for the memory card game. It replaces the fixed 6x6 compare block.
- Takes player card selections (button A strobe plus board address) and fetches each card value from the external card memory.
- Compares the two selected cards and keeps a per-card matched bitmap, a pair counter and the game-over flag.
- Sits between the input/cursor logic and the VGA renderer. The renderer uses first/second/matched to draw face-up cards.

Parameters:
- NUM_CARDS, 36, number of cards on the board. Must be even; an odd value is an elaboration error.
- ADDR_W, 6, card address width. Must satisfy 2**ADDR_W >= NUM_CARDS.
- VALUE_W, 6, width of a card value word in the card memory.
- SHOW_CYCLES, 25000000, cycles a mismatched pair stays face-up. Must be >= 1.
- MATCH_MODE, 0, comparison mode:
  - 0 = all VALUE_W bits must be equal.
  - 1 = bit 0 is ignored, so the pair id is value[VALUE_W-1:1].

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  one-cycle select strobe (debounced button A).
- sel_addr  in  ADDR_W  board address of the card being selected; sampled when sel=1.
- mem_raddr  out  ADDR_W  registered read address to the card memory.
- mem_rdata  in  VALUE_W  card memory data; valid the cycle after mem_raddr holds the address.
- first_valid  out  1  first card of the current turn is face-up.
- first_addr  out  ADDR_W  address of the first card.
- second_valid  out  1  second card is face-up.
- second_addr  out  ADDR_W  address of the second card.
- match_pulse  out  1  one-cycle pulse: pair matched.
- mismatch_pulse  out  1  one-cycle pulse: pair did not match.
- reject_pulse  out  1  one-cycle pulse: selection refused.
- matched  out  NUM_CARDS  bit i = card i has been removed as part of a pair.
- pairs_found  out  $clog2(NUM_CARDS/2+1)  number of pairs matched so far.
- game_over  out  1  all pairs found.
- busy  out  1  high in any state other than IDLE, WAIT2 or DONE.

Behaviour:
- Reset (synchronous, one cycle, any state, including mid-fetch or SHOW):
  - state=IDLE.
  - All outputs 0: mem_raddr, first/second addr and valid, pulses, matched, pairs_found, game_over.
  - Internal first_val=0 and the SHOW counter=0.
- FSM states: IDLE, RD1, LT1, WAIT2, RD2, LT2, SHOW, DONE.
- sel is acted on only in IDLE and WAIT2. In all other states it is ignored: no reject, no queueing.
- Reject rules (state unchanged, reject_pulse=1 the following cycle):
  - sel_addr >= NUM_CARDS.
  - matched[sel_addr]=1.
  - In WAIT2, sel_addr==first_addr.
- IDLE + accepted sel: mem_raddr<=sel_addr, first_addr<=sel_addr, first_valid<=1, go to RD1.
- RD1 -> LT1: the address is presented to memory.
- LT1: first_val<=mem_rdata, go to WAIT2.
- WAIT2 + accepted sel: mem_raddr<=sel_addr, second_addr<=sel_addr, second_valid<=1, go to RD2.
- RD2 -> LT2.
- LT2: compare mem_rdata with first_val according to MATCH_MODE.
  - Match:
    - matched[first_addr] and matched[second_addr] <= 1.
    - pairs_found += 1.
    - match_pulse <= 1.
    - first_valid and second_valid <= 0.
    - Next state is DONE if the new count equals NUM_CARDS/2, otherwise IDLE.
  - Mismatch: mismatch_pulse <= 1, counter <= SHOW_CYCLES-1, go to SHOW.
- SHOW:
  - Both cards are held face-up and the counter decrements each cycle.
  - When the counter is 0: first_valid and second_valid <= 0, go to IDLE.
  - SHOW lasts exactly SHOW_CYCLES cycles.
- DONE: game_over=1 and it holds until reset. sel is ignored.
- Latency:
  - Accepted second sel at edge N gives the match/mismatch pulse during cycle N+3.
  - matched and pairs_found update in that same cycle.
- Other timing rules:
  - Every pulse output is registered and lasts exactly one cycle.
  - first_addr and second_addr hold their last value when the matching valid is low.
  - pairs_found never exceeds NUM_CARDS/2 and never wraps.

Test Plan:
- Match, defaults, card memory with [3]=5 and [17]=5:
  - Stimulus: sel addr 3 at cycle 0, sel addr 17 at cycle 5.
  - first_valid=1 from cycle 1.
  - match_pulse only in cycle 8.
  - matched[3] and matched[17] =1, pairs_found=1, valids=0 in cycle 8.
  - busy=0 in cycle 8.
- Mismatch, SHOW_CYCLES=4, [0]=1, [1]=2:
  - Stimulus: select 0, then 1.
  - mismatch_pulse for exactly one cycle.
  - Both valids stay high for exactly 4 cycles, then clear.
  - matched stays all-zero.
- Rejects:
  - In IDLE: sel addr 36, then a matched card.
  - In WAIT2: reselect first_addr.
  - Each gives one reject_pulse and no change of state or outputs.
  - A sel during RD1 or SHOW gives no reject and no effect.
- MATCH_MODE=1, values 6 and 7: match_pulse. Values 6 and 8: mismatch_pulse.
- Game over, NUM_CARDS=4, values [2,9,9,2]:
  - Match pairs (1,2) and then (0,3).
  - game_over=1 in the same cycle as the second match_pulse.
  - pairs_found=2; later sel has no effect.
- Reset mid-operation:
  - Assert reset during SHOW, and separately during RD2.
  - On the next cycle all outputs are 0 and state is IDLE.
  - A fresh select then works normally.

Source files
------------

// File: rtl/card_match_engine.sv
// Pair-matching engine for the memory card game: fetches two selected cards
// from the external card memory, compares them and tracks matched cards.
module card_match_engine #(
  parameter int NUM_CARDS   = 36,
  parameter int ADDR_W      = 6,
  parameter int VALUE_W     = 6,
  parameter int SHOW_CYCLES = 25000000,
  parameter int MATCH_MODE  = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 sel,
  input  logic [ADDR_W-1:0]                    sel_addr,
  output logic [ADDR_W-1:0]                    mem_raddr,
  input  logic [VALUE_W-1:0]                   mem_rdata,
  output logic                                 first_valid,
  output logic [ADDR_W-1:0]                    first_addr,
  output logic                                 second_valid,
  output logic [ADDR_W-1:0]                    second_addr,
  output logic                                 match_pulse,
  output logic                                 mismatch_pulse,
  output logic                                 reject_pulse,
  output logic [NUM_CARDS-1:0]                 matched,
  output logic [$clog2(NUM_CARDS/2+1)-1:0]     pairs_found,
  output logic                                 game_over,
  output logic                                 busy
);

  localparam int PF_W       = $clog2(NUM_CARDS / 2 + 1);
  localparam int CNT_W      = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int ADDR_SPAN  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]     NUM_CARDS_W = (ADDR_W + 1)'(NUM_CARDS);
  localparam logic [PF_W-1:0]     ALL_PAIRS   = PF_W'(NUM_CARDS / 2);
  localparam logic [CNT_W-1:0]    SHOW_LOAD   = CNT_W'(SHOW_CYCLES - 1);
  // Mode 1 drops bit 0 so the pair id is the upper value bits.
  localparam logic [VALUE_W-1:0]  CMP_MASK    =
    (MATCH_MODE == 1) ? {{(VALUE_W - 1){1'b1}}, 1'b0} : {VALUE_W{1'b1}};

  if (NUM_CARDS % 2 != 0) begin : g_bad_num_cards
    $error("card_match_engine: NUM_CARDS must be even");
  end
  if (ADDR_SPAN < NUM_CARDS) begin : g_bad_addr_w
    $error("card_match_engine: ADDR_W too narrow for NUM_CARDS");
  end
  if (SHOW_CYCLES < 1) begin : g_bad_show
    $error("card_match_engine: SHOW_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_LT1, S_WAIT2, S_RD2, S_LT2, S_SHOW, S_DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [VALUE_W-1:0]   first_val;
  logic [CNT_W-1:0]     show_cnt;
  logic                 sel_accept;
  logic                 sel_reject;
  logic                 addr_bad;
  logic                 values_equal;
  logic [PF_W-1:0]      pairs_next;
  logic [ADDR_SPAN-1:0] matched_ext;
  logic [NUM_CARDS-1:0] pair_mask;

  assign matched_ext  = ADDR_SPAN'(matched);
  assign addr_bad     = ({1'b0, sel_addr} >= NUM_CARDS_W) || matched_ext[sel_addr];
  assign values_equal = ((mem_rdata ^ first_val) & CMP_MASK) == '0;
  assign pairs_next   = pairs_found + PF_W'(1);
  assign pair_mask    = (NUM_CARDS'(1) << first_addr) | (NUM_CARDS'(1) << second_addr);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_next = state;
    sel_accept = 1'b0;
    sel_reject = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (sel) begin
          if (addr_bad) begin
            sel_reject = 1'b1;
          end else begin
            sel_accept = 1'b1;
            state_next = S_RD1;
          end
        end
      end
      S_RD1: state_next = S_LT1;
      S_LT1: state_next = S_WAIT2;
      S_WAIT2: begin
        busy = 1'b0;
        if (sel) begin
          if (addr_bad || (sel_addr == first_addr)) begin
            sel_reject = 1'b1;
          end else begin
            sel_accept = 1'b1;
            state_next = S_RD2;
          end
        end
      end
      S_RD2: state_next = S_LT2;
      S_LT2: begin
        if (!values_equal)               state_next = S_SHOW;
        else if (pairs_next == ALL_PAIRS) state_next = S_DONE;
        else                              state_next = S_IDLE;
      end
      S_SHOW: if (show_cnt == '0) state_next = S_IDLE;
      S_DONE: busy = 1'b0;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the matched bitmap is ordinary flop state and is cleared with everything else.
      mem_raddr      <= '0;
      first_valid    <= 1'b0;
      first_addr     <= '0;
      second_valid   <= 1'b0;
      second_addr    <= '0;
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      reject_pulse   <= 1'b0;
      matched        <= '0;
      pairs_found    <= '0;
      game_over      <= 1'b0;
      first_val      <= '0;
      show_cnt       <= '0;
    end else begin
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      reject_pulse   <= sel_reject;

      if (sel_accept) begin
        mem_raddr <= sel_addr;
        if (state == S_IDLE) begin
          first_addr  <= sel_addr;
          first_valid <= 1'b1;
        end else begin
          second_addr  <= sel_addr;
          second_valid <= 1'b1;
        end
      end

      if (state == S_LT1) first_val <= mem_rdata;

      if (state == S_LT2) begin
        if (values_equal) begin
          matched      <= matched | pair_mask;
          pairs_found  <= pairs_next;
          match_pulse  <= 1'b1;
          first_valid  <= 1'b0;
          second_valid <= 1'b0;
          if (pairs_next == ALL_PAIRS) game_over <= 1'b1;
        end else begin
          mismatch_pulse <= 1'b1;
          show_cnt       <= SHOW_LOAD;
        end
      end

      if (state == S_SHOW) begin
        if (show_cnt == '0) begin
          first_valid  <= 1'b0;
          second_valid <= 1'b0;
        end else begin
          show_cnt <= show_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_card_match_engine.sv
// Self-checking bench for card_match_engine: directed scenarios on four
// parameterisations plus a randomized game checked against a pair-level model.
module tb_card_match_engine;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sel_v;
  logic [5:0] sel_addr;
  int         total = 0;
  int         bad   = 0;

  always #5 clock = ~clock;

  // Instance A: defaults. Instance B: SHOW_CYCLES=4. Instance C: MATCH_MODE=1.
  // Instance D: NUM_CARDS=4, ADDR_W=3.
  logic [5:0]  a_raddr, a_rdata, a_fa, a_sa;
  logic        a_fv, a_sv, a_mp, a_mmp, a_rp, a_go, a_busy;
  logic [35:0] a_matched;
  logic [4:0]  a_pairs;
  logic [5:0]  b_raddr, b_rdata, b_fa, b_sa;
  logic        b_fv, b_sv, b_mp, b_mmp, b_rp, b_go, b_busy;
  logic [35:0] b_matched;
  logic [4:0]  b_pairs;
  logic [5:0]  c_raddr, c_rdata, c_fa, c_sa;
  logic        c_fv, c_sv, c_mp, c_mmp, c_rp, c_go, c_busy;
  logic [35:0] c_matched;
  logic [4:0]  c_pairs;
  logic [2:0]  d_raddr, d_fa, d_sa;
  logic [5:0]  d_rdata;
  logic        d_fv, d_sv, d_mp, d_mmp, d_rp, d_go, d_busy;
  logic [3:0]  d_matched;
  logic [1:0]  d_pairs;

  logic [5:0] mem_a [64];
  logic [5:0] mem_b [64];
  logic [5:0] mem_c [64];
  logic [5:0] mem_d [8];

  always @(posedge clock) begin
    a_rdata <= mem_a[a_raddr];
    b_rdata <= mem_b[b_raddr];
    c_rdata <= mem_c[c_raddr];
    d_rdata <= mem_d[d_raddr];
  end

  card_match_engine u_a (
    .clock(clock), .reset(reset), .sel(sel_v[0]), .sel_addr(sel_addr),
    .mem_raddr(a_raddr), .mem_rdata(a_rdata),
    .first_valid(a_fv), .first_addr(a_fa), .second_valid(a_sv), .second_addr(a_sa),
    .match_pulse(a_mp), .mismatch_pulse(a_mmp), .reject_pulse(a_rp),
    .matched(a_matched), .pairs_found(a_pairs), .game_over(a_go), .busy(a_busy)
  );

  card_match_engine #(.SHOW_CYCLES(4)) u_b (
    .clock(clock), .reset(reset), .sel(sel_v[1]), .sel_addr(sel_addr),
    .mem_raddr(b_raddr), .mem_rdata(b_rdata),
    .first_valid(b_fv), .first_addr(b_fa), .second_valid(b_sv), .second_addr(b_sa),
    .match_pulse(b_mp), .mismatch_pulse(b_mmp), .reject_pulse(b_rp),
    .matched(b_matched), .pairs_found(b_pairs), .game_over(b_go), .busy(b_busy)
  );

  card_match_engine #(.SHOW_CYCLES(3), .MATCH_MODE(1)) u_c (
    .clock(clock), .reset(reset), .sel(sel_v[2]), .sel_addr(sel_addr),
    .mem_raddr(c_raddr), .mem_rdata(c_rdata),
    .first_valid(c_fv), .first_addr(c_fa), .second_valid(c_sv), .second_addr(c_sa),
    .match_pulse(c_mp), .mismatch_pulse(c_mmp), .reject_pulse(c_rp),
    .matched(c_matched), .pairs_found(c_pairs), .game_over(c_go), .busy(c_busy)
  );

  card_match_engine #(.NUM_CARDS(4), .ADDR_W(3), .SHOW_CYCLES(2)) u_d (
    .clock(clock), .reset(reset), .sel(sel_v[3]), .sel_addr(sel_addr[2:0]),
    .mem_raddr(d_raddr), .mem_rdata(d_rdata),
    .first_valid(d_fv), .first_addr(d_fa), .second_valid(d_sv), .second_addr(d_sa),
    .match_pulse(d_mp), .mismatch_pulse(d_mmp), .reject_pulse(d_rp),
    .matched(d_matched), .pairs_found(d_pairs), .game_over(d_go), .busy(d_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Select is held for one edge; returns at the sample point after that edge.
  task automatic pulse(input int inst, input logic [5:0] addr);
    sel_v[inst] = 1'b1;
    sel_addr    = addr;
    step();
    sel_v       = '0;
  endtask

  int          vals [36];
  logic [35:0] exp_m;
  int          exp_pairs;
  int          ra, rb, partner, base, tmp, jj;
  logic        rej, is_m;

  initial begin
    sel_v    = '0;
    sel_addr = '0;
    reset    = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 6'(i);
      mem_b[i] = 6'(i);
      mem_c[i] = 6'(i);
    end
    mem_a[3] = 6'd5;  mem_a[17] = 6'd5;
    mem_b[0] = 6'd1;  mem_b[1]  = 6'd2;
    mem_c[0] = 6'd6;  mem_c[1]  = 6'd7;  mem_c[4] = 6'd6;  mem_c[2] = 6'd8;
    for (int i = 0; i < 8; i++) mem_d[i] = 6'd0;
    mem_d[0] = 6'd2;  mem_d[1] = 6'd9;  mem_d[2] = 6'd9;  mem_d[3] = 6'd2;
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_raddr", a_raddr, 0);
    check("rst_fv", a_fv, 0);
    check("rst_matched", a_matched, 0);
    check("rst_pairs", a_pairs, 0);
    check("rst_go", a_go, 0);
    check("rst_busy", a_busy, 0);
    check("rst_d_matched", d_matched, 0);

    // Match with defaults: sel 3 at cycle 0, sel 17 at cycle 5
    pulse(0, 6'd3);                                   // cycle 1
    check("a_fv_c1", a_fv, 1);
    check("a_fa_c1", a_fa, 3);
    check("a_raddr_c1", a_raddr, 3);
    check("a_busy_c1", a_busy, 1);
    step(); step();                                   // cycle 3, WAIT2
    check("a_busy_wait2", a_busy, 0);
    step(); step();                                   // cycle 5
    pulse(0, 6'd17);                                  // cycle 6
    check("a_sv_c6", a_sv, 1);
    check("a_sa_c6", a_sa, 17);
    check("a_busy_c6", a_busy, 1);
    step();                                           // cycle 7
    check("a_mp_c7", a_mp, 0);
    step();                                           // cycle 8
    check("a_mp_c8", a_mp, 1);
    check("a_mmp_c8", a_mmp, 0);
    check("a_matched_c8", a_matched, (64'd1 << 3) | (64'd1 << 17));
    check("a_pairs_c8", a_pairs, 1);
    check("a_fv_c8", a_fv, 0);
    check("a_sv_c8", a_sv, 0);
    check("a_busy_c8", a_busy, 0);
    step();                                           // cycle 9
    check("a_mp_c9", a_mp, 0);

    // Rejects in IDLE: out of range, then an already matched card
    pulse(0, 6'd36);
    check("a_rej_oob", a_rp, 1);
    check("a_rej_oob_fv", a_fv, 0);
    check("a_rej_oob_busy", a_busy, 0);
    step();
    check("a_rej_oob_clear", a_rp, 0);
    pulse(0, 6'd3);
    check("a_rej_matched", a_rp, 1);
    check("a_rej_matched_fv", a_fv, 0);
    step();
    pulse(0, 6'd10);                                  // RD1
    check("a_acc10_rp", a_rp, 0);
    check("a_acc10_fa", a_fa, 10);
    pulse(0, 6'd20);                                  // sel during RD1, now LT1
    check("a_rd1_sel_rp", a_rp, 0);
    check("a_rd1_sel_fa", a_fa, 10);
    check("a_rd1_sel_sv", a_sv, 0);
    step();                                           // WAIT2
    pulse(0, 6'd10);
    check("a_rej_same", a_rp, 1);
    check("a_rej_same_sv", a_sv, 0);
    check("a_rej_same_busy", a_busy, 0);
    step();
    pulse(0, 6'd17);
    check("a_rej_w2_matched", a_rp, 1);
    step();
    pulse(0, 6'd11);                                  // RD2
    check("a_rd2_sv", a_sv, 1);
    check("a_rd2_busy", a_busy, 1);

    // Reset during RD2
    reset = 1'b1;
    step();
    check("a_rrd2_fv", a_fv, 0);
    check("a_rrd2_sv", a_sv, 0);
    check("a_rrd2_fa", a_fa, 0);
    check("a_rrd2_sa", a_sa, 0);
    check("a_rrd2_raddr", a_raddr, 0);
    check("a_rrd2_matched", a_matched, 0);
    check("a_rrd2_pairs", a_pairs, 0);
    check("a_rrd2_busy", a_busy, 0);
    reset = 1'b0;
    pulse(0, 6'd3);
    check("a_fresh_fv", a_fv, 1);
    step(); step();
    pulse(0, 6'd17);
    step(); step();
    check("a_fresh_mp", a_mp, 1);
    check("a_fresh_pairs", a_pairs, 1);

    // Mismatch with SHOW_CYCLES=4
    pulse(1, 6'd0); step(); step();
    pulse(1, 6'd1); step(); step();                   // SHOW cycle 1
    check("b_mmp_s1", b_mmp, 1);
    check("b_mp_s1", b_mp, 0);
    check("b_valids_s1", {b_fv, b_sv}, 2'b11);
    check("b_busy_s1", b_busy, 1);
    pulse(1, 6'd5);                                   // sel during SHOW, now SHOW cycle 2
    check("b_mmp_s2", b_mmp, 0);
    check("b_show_sel_rp", b_rp, 0);
    check("b_show_sel_fa", b_fa, 0);
    check("b_valids_s2", {b_fv, b_sv}, 2'b11);
    step();
    check("b_valids_s3", {b_fv, b_sv}, 2'b11);
    step();
    check("b_valids_s4", {b_fv, b_sv}, 2'b11);
    step();
    check("b_valids_end", {b_fv, b_sv}, 2'b00);
    check("b_busy_end", b_busy, 0);
    check("b_matched_end", b_matched, 0);
    check("b_pairs_end", b_pairs, 0);
    check("b_sa_hold", b_sa, 1);

    // Reset during SHOW
    pulse(1, 6'd0); step(); step();
    pulse(1, 6'd1); step(); step();
    check("b_in_show", b_mmp, 1);
    reset = 1'b1;
    step();
    check("b_rshow_valids", {b_fv, b_sv}, 2'b00);
    check("b_rshow_addrs", {b_fa, b_sa}, 0);
    check("b_rshow_pulses", {b_mp, b_mmp, b_rp}, 0);
    check("b_rshow_busy", b_busy, 0);
    check("b_rshow_raddr", b_raddr, 0);
    reset = 1'b0;
    pulse(1, 6'd2);
    check("b_fresh_fv", b_fv, 1);
    check("b_fresh_fa", b_fa, 2);

    // MATCH_MODE=1: 6/7 match, 6/8 mismatch
    pulse(2, 6'd0); step(); step();
    pulse(2, 6'd1); step(); step();
    check("c_67_mp", c_mp, 1);
    check("c_67_mmp", c_mmp, 0);
    check("c_67_matched", c_matched, 64'b11);
    step();
    pulse(2, 6'd4); step(); step();
    pulse(2, 6'd2); step(); step();
    check("c_68_mmp", c_mmp, 1);
    check("c_68_mp", c_mp, 0);
    check("c_68_pairs", c_pairs, 1);

    // Game over with NUM_CARDS=4
    pulse(3, 6'd4);
    check("d_rej_oob", d_rp, 1);
    step();
    pulse(3, 6'd1); step(); step();
    pulse(3, 6'd2); step(); step();
    check("d_m1_mp", d_mp, 1);
    check("d_m1_pairs", d_pairs, 1);
    check("d_m1_go", d_go, 0);
    check("d_m1_matched", d_matched, 4'b0110);
    step();
    pulse(3, 6'd0); step(); step();
    pulse(3, 6'd3); step(); step();
    check("d_m2_mp", d_mp, 1);
    check("d_m2_pairs", d_pairs, 2);
    check("d_m2_go", d_go, 1);
    check("d_m2_matched", d_matched, 4'b1111);
    check("d_m2_busy", d_busy, 0);
    step();
    pulse(3, 6'd1);
    check("d_done_rp", d_rp, 0);
    check("d_done_fv", d_fv, 0);
    check("d_done_go", d_go, 1);
    step();
    check("d_done_pairs", d_pairs, 2);
    check("d_done_mp", d_mp, 0);

    // Randomized full game on instance B against a pair-level model
    reset = 1'b1;
    step();
    reset = 1'b0;
    base = int'($urandom_range(0, 63));
    for (int i = 0; i < 36; i++) vals[i] = ((i / 2) * 7 + base) % 64;
    for (int i = 35; i > 0; i--) begin
      jj = int'($urandom_range(0, i));
      tmp = vals[i]; vals[i] = vals[jj]; vals[jj] = tmp;
    end
    for (int i = 0; i < 36; i++) mem_b[i] = 6'(vals[i]);
    exp_m     = '0;
    exp_pairs = 0;
    for (int turn = 0; turn < 300 && exp_pairs < 18; turn++) begin
      ra  = int'($urandom_range(0, 39));
      rej = (ra >= 36) || exp_m[ra % 36];
      pulse(1, 6'(ra));
      check("rnd_rej1", b_rp, rej);
      if (rej) begin
        step();
        continue;
      end
      check("rnd_fa", b_fa, ra);
      step(); step();
      partner = 0;
      for (int j = 0; j < 36; j++)
        if (j != ra && vals[j] == vals[ra]) partner = j;
      rb = ($urandom_range(0, 1) == 1) ? partner : int'($urandom_range(0, 39));
      if ((rb >= 36) || exp_m[rb % 36] || (rb == ra)) begin
        pulse(1, 6'(rb));
        check("rnd_rej2", b_rp, 1);
        step();
        rb = partner;
      end
      pulse(1, 6'(rb));
      step(); step();
      is_m = (vals[ra] == vals[rb]);
      if (is_m) begin
        exp_m[ra] = 1'b1;
        exp_m[rb] = 1'b1;
        exp_pairs++;
      end
      check("rnd_mp", b_mp, is_m);
      check("rnd_mmp", b_mmp, !is_m);
      check("rnd_pairs", b_pairs, exp_pairs);
      check("rnd_matched", b_matched, exp_m);
      check("rnd_go", b_go, exp_pairs == 18);
      if (!is_m) begin
        repeat (4) step();
        check("rnd_show_end", b_fv, 0);
      end else begin
        step();
      end
    end
    check("rnd_final_go", b_go, exp_pairs == 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
